// File: rtl/usb_pkg.sv
// Shared types and constants for the USB receive-side transaction sequencer.
// Holds the FSM state enum, handshake encodings and default parameters.
package usb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT_TX,
      ST_WAIT_RESP,
      ST_HANDSHAKE,
      ST_FINISH
   } txn_state_t;

   localparam logic HS_ACK = 1'b1;
   localparam logic HS_NAK = 1'b0;

   localparam int DEF_TIMEOUT_CYCLES = 256;
   localparam int DEF_MAX_ATTEMPTS   = 8;

endpackage

// File: rtl/usb_timeout_timer.sv
// Clear/enable up-counter with a terminal-count flag.
// Ports: clk, rst_L, clr (sync clear), en (count), tc (count == TIMEOUT_CYCLES-1).
module usb_timeout_timer
   import usb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst_L,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int W = $clog2(TIMEOUT_CYCLES);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // Count k-1 during the k-th enabled cycle, so tc marks the last one.
   assign tc = (cnt_q == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/usb_rx_txn_sequencer.sv
// Host transaction sequencer: launch packet, await decoder verdict, handshake, retry.
// Ports: txn_start/txn_is_in in, tx_go/tx_done, dec_* verdicts, hs_send/hs_is_ack/hs_done,
// txn_done/txn_ok/rx_data/attempts_used results. USB_RX_SEQ_STATS_EN adds timeout_cnt/err_cnt.
module usb_rx_txn_sequencer
   import usb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int MAX_ATTEMPTS   = DEF_MAX_ATTEMPTS
) (
   input  logic        clk,
   input  logic        rst_L,
   input  logic        txn_start,
   input  logic        txn_is_in,
   output logic        tx_go,
   input  logic        tx_done,
   input  logic        dec_havepkt,
   input  logic        dec_haveack,
   input  logic        dec_havenak,
   input  logic        dec_error,
   input  logic [63:0] dec_data,
   output logic        hs_send,
   output logic        hs_is_ack,
   input  logic        hs_done,
   output logic        txn_done,
   output logic        txn_ok,
   output logic [63:0] rx_data,
`ifdef USB_RX_SEQ_STATS_EN
   output logic [15:0] timeout_cnt,
   output logic [15:0] err_cnt,
`endif
   output logic [3:0]  attempts_used
);

   txn_state_t  state_q, state_d;
   logic [3:0]  attempt_q, attempt_d;
   logic [3:0]  used_q, used_d;
   logic        is_in_q, is_in_d;
   logic        hs_ack_q, hs_ack_d;
   logic        ok_q, ok_d;
   logic [63:0] rx_q, rx_d;
   logic        retry;
   logic        tmr_clr;
   logic        tmr_tc;
   logic        in_resp;
   logic        any_verdict;

   assign in_resp     = (state_q == ST_WAIT_RESP);
   assign any_verdict = dec_error | dec_havepkt | dec_haveack | dec_havenak;

   usb_timeout_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_tmr (
      .clk  (clk),
      .rst_L(rst_L),
      .clr  (tmr_clr),
      .en   (in_resp),
      .tc   (tmr_tc)
   );

   always_comb begin
      state_d   = state_q;
      attempt_d = attempt_q;
      used_d    = used_q;
      is_in_d   = is_in_q;
      hs_ack_d  = hs_ack_q;
      ok_d      = ok_q;
      rx_d      = rx_q;
      retry     = 1'b0;
      tmr_clr   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (txn_start) begin
               is_in_d   = txn_is_in;
               attempt_d = 4'd1;
               ok_d      = 1'b0;
               state_d   = ST_LAUNCH;
            end
         end
         ST_LAUNCH: state_d = ST_WAIT_TX;
         ST_WAIT_TX: begin
            if (tx_done) begin
               tmr_clr = 1'b1;
               state_d = ST_WAIT_RESP;
            end
         end
         ST_WAIT_RESP: begin
            if (dec_error) begin
               if (is_in_q) begin
                  hs_ack_d = HS_NAK;
                  state_d  = ST_HANDSHAKE;
               end else begin
                  retry = 1'b1;
               end
            end else if (dec_havepkt) begin
               if (is_in_q) begin
                  rx_d     = dec_data;
                  hs_ack_d = HS_ACK;
                  state_d  = ST_HANDSHAKE;
               end else begin
                  retry = 1'b1;
               end
            end else if (dec_haveack) begin
               if (is_in_q) begin
                  retry = 1'b1;
               end else begin
                  ok_d    = 1'b1;
                  used_d  = attempt_q;
                  state_d = ST_FINISH;
               end
            end else if (dec_havenak || tmr_tc) begin
               retry = 1'b1;
            end
         end
         ST_HANDSHAKE: begin
            if (hs_done) begin
               if (hs_ack_q == HS_ACK) begin
                  ok_d    = 1'b1;
                  used_d  = attempt_q;
                  state_d = ST_FINISH;
               end else begin
                  retry = 1'b1;
               end
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      if (retry) begin
         if (attempt_q == 4'(MAX_ATTEMPTS)) begin
            ok_d    = 1'b0;
            used_d  = attempt_q;
            state_d = ST_FINISH;
         end else begin
            attempt_d = attempt_q + 4'd1;
            state_d   = ST_LAUNCH;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         state_q   <= ST_IDLE;
         attempt_q <= '0;
         used_q    <= '0;
         is_in_q   <= 1'b0;
         hs_ack_q  <= 1'b0;
         ok_q      <= 1'b0;
         rx_q      <= '0;
      end else begin
         state_q   <= state_d;
         attempt_q <= attempt_d;
         used_q    <= used_d;
         is_in_q   <= is_in_d;
         hs_ack_q  <= hs_ack_d;
         ok_q      <= ok_d;
         rx_q      <= rx_d;
      end
   end

   assign tx_go         = (state_q == ST_LAUNCH);
   assign hs_send       = (state_q == ST_HANDSHAKE);
   assign hs_is_ack     = hs_send & hs_ack_q;
   assign txn_done      = (state_q == ST_FINISH);
   assign txn_ok        = ok_q;
   assign rx_data       = rx_q;
   assign attempts_used = used_q;

`ifdef USB_RX_SEQ_STATS_EN
   logic [15:0] to_q, err_q;
   logic        to_hit, err_hit;

   // A verdict in the terminal cycle wins, so only a silent tc is a timeout.
   assign to_hit  = in_resp & tmr_tc & ~any_verdict;
   assign err_hit = in_resp & dec_error;

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         to_q  <= '0;
         err_q <= '0;
      end else begin
         if (to_hit && to_q != 16'hFFFF)
            to_q <= to_q + 16'd1;
         if (err_hit && err_q != 16'hFFFF)
            err_q <= err_q + 16'd1;
      end
   end

   assign timeout_cnt = to_q;
   assign err_cnt     = err_q;
`else
   logic unused_ok;
   assign unused_ok = any_verdict;
`endif

endmodule

// File: tb/tb_usb_rx_txn_sequencer.sv
// Directed self-checking bench for usb_rx_txn_sequencer.
// Runs with TIMEOUT_CYCLES=16, MAX_ATTEMPTS=3; inputs driven and outputs sampled on negedge.
module tb_usb_rx_txn_sequencer;

   localparam int TO = 16;
   localparam int MA = 3;

   logic        clk = 1'b0;
   logic        rst_L;
   logic        txn_start, txn_is_in;
   logic        tx_go, tx_done;
   logic        dec_havepkt, dec_haveack, dec_havenak, dec_error;
   logic [63:0] dec_data;
   logic        hs_send, hs_is_ack, hs_done;
   logic        txn_done, txn_ok;
   logic [63:0] rx_data;
   logic [3:0]  attempts_used;
`ifdef USB_RX_SEQ_STATS_EN
   logic [15:0] timeout_cnt, err_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   usb_rx_txn_sequencer #(
      .TIMEOUT_CYCLES(TO),
      .MAX_ATTEMPTS  (MA)
   ) dut (
      .clk          (clk),
      .rst_L        (rst_L),
      .txn_start    (txn_start),
      .txn_is_in    (txn_is_in),
      .tx_go        (tx_go),
      .tx_done      (tx_done),
      .dec_havepkt  (dec_havepkt),
      .dec_haveack  (dec_haveack),
      .dec_havenak  (dec_havenak),
      .dec_error    (dec_error),
      .dec_data     (dec_data),
      .hs_send      (hs_send),
      .hs_is_ack    (hs_is_ack),
      .hs_done      (hs_done),
      .txn_done     (txn_done),
      .txn_ok       (txn_ok),
      .rx_data      (rx_data),
`ifdef USB_RX_SEQ_STATS_EN
      .timeout_cnt  (timeout_cnt),
      .err_cnt      (err_cnt),
`endif
      .attempts_used(attempts_used)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Leaves the bench at the negedge where LAUNCH (tx_go) is visible.
   task automatic start_txn(input logic in);
      txn_start = 1'b1;
      txn_is_in = in;
      tick();
      txn_start = 1'b0;
   endtask

   // From LAUNCH: check tx_go, complete tx, end at first WAIT_RESP cycle.
   task automatic launch(input string tag);
      check(tag, tx_go, 1'b1);
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
   endtask

   task automatic pulse_hs();
      hs_done = 1'b1;
      tick();
      hs_done = 1'b0;
   endtask

   task automatic done_chk(input string tag, input logic ok,
                           input logic [3:0] used);
      check({tag, "_done"}, txn_done, 1'b1);
      check({tag, "_ok"}, txn_ok, ok);
      check({tag, "_used"}, attempts_used, used);
   endtask

   initial begin
      int n;
      rst_L = 1'b0;
      txn_start = 0; txn_is_in = 0; tx_done = 0; hs_done = 0;
      dec_havepkt = 0; dec_haveack = 0; dec_havenak = 0; dec_error = 0;
      dec_data = '0;
      tick(); tick();
      check("rst_go", tx_go, 1'b0);
      check("rst_hs", hs_send, 1'b0);
      check("rst_done", txn_done, 1'b0);
      check("rst_ok", txn_ok, 1'b0);
      check("rst_rx", rx_data, 64'h0);
      check("rst_used", attempts_used, 4'd0);
      rst_L = 1'b1;
      tick();

      // IN success on first attempt
      start_txn(1'b1);
      launch("in_go");
      dec_havepkt = 1'b1;
      dec_data    = 64'hDEADBEEF_01234567;
      tick();
      dec_havepkt = 1'b0;
      dec_data    = '0;
      check("in_hs", hs_send, 1'b1);
      check("in_ack", hs_is_ack, 1'b1);
      pulse_hs();
      done_chk("in", 1'b1, 4'd1);
      check("in_rx", rx_data, 64'hDEADBEEF_01234567);
      tick();
      check("in_idle", txn_done, 1'b0);

      // OUT: NAK then ACK; txn_start mid-flight must be ignored
      start_txn(1'b0);
      check("out_okclr", txn_ok, 1'b0);
      launch("out_go1");
      txn_start = 1'b1;
      dec_havenak = 1'b1;
      tick();
      dec_havenak = 1'b0;
      txn_start = 1'b0;
      launch("out_go2");
      dec_haveack = 1'b1;
      tick();
      dec_haveack = 1'b0;
      done_chk("out", 1'b1, 4'd2);
      tick();

      // IN CRC error: NAK handshake, relaunch, then good packet
      start_txn(1'b1);
      launch("crc_go1");
      dec_error = 1'b1;
      tick();
      dec_error = 1'b0;
      check("crc_hs", hs_send, 1'b1);
      check("crc_nak", hs_is_ack, 1'b0);
      pulse_hs();
      launch("crc_go2");
      dec_havepkt = 1'b1;
      dec_data    = 64'h0123_4567_89AB_CDEF;
      tick();
      dec_havepkt = 1'b0;
      check("crc_ack", hs_is_ack, 1'b1);
      pulse_hs();
      done_chk("crc", 1'b1, 4'd2);
      check("crc_rx", rx_data, 64'h0123_4567_89AB_CDEF);
      tick();

      // Timeout exhaustion: tx_done sampled at edge E, WAIT_RESP spans 16
      // cycles, so the next state shows 17 negedges after tx_done is driven.
      start_txn(1'b0);
      for (int a = 1; a <= MA; a++) begin
         check("to_go", tx_go, 1'b1);
         tick();
         tx_done = 1'b1;
         tick();
         tx_done = 1'b0;
         n = 1;
         while (!(tx_go || txn_done) && n < 100) begin
            tick();
            n++;
         end
         check("to_gap", n, 17);
         if (a < MA)
            check("to_relaunch", tx_go, 1'b1);
      end
      done_chk("to", 1'b0, 4'd3);
`ifdef USB_RX_SEQ_STATS_EN
      tick();
      check("to_cnt", timeout_cnt, 16'd3);
      check("err_cnt", err_cnt, 16'd1);
`else
      tick();
`endif

      // error + havepkt together: error wins (NAK)
      start_txn(1'b1);
      launch("sim_go1");
      dec_error   = 1'b1;
      dec_havepkt = 1'b1;
      dec_data    = 64'hFFFF_0000_FFFF_0000;
      tick();
      dec_error   = 1'b0;
      dec_havepkt = 1'b0;
      check("sim_hs", hs_send, 1'b1);
      check("sim_nak", hs_is_ack, 1'b0);
      check("sim_rx", rx_data, 64'h0123_4567_89AB_CDEF);
      pulse_hs();
      check("sim_go2", tx_go, 1'b1);
      tick(); tick();
      check("sim_idle", txn_done, 1'b0);
      rst_L = 1'b0;
      tick();
      rst_L = 1'b1;
      tick();

      // Verdict in the 16th (timeout) WAIT_RESP cycle is taken
      start_txn(1'b0);
      launch("edge_go");
      for (int i = 0; i < TO - 1; i++)
         tick();
      dec_haveack = 1'b1;
      tick();
      dec_haveack = 1'b0;
      done_chk("edge", 1'b1, 4'd1);
      tick();

      // Reset mid-HANDSHAKE
      start_txn(1'b1);
      launch("mr_go");
      dec_havepkt = 1'b1;
      dec_data    = 64'hA5A5_A5A5_5A5A_5A5A;
      tick();
      dec_havepkt = 1'b0;
      check("mr_hs", hs_send, 1'b1);
      rst_L = 1'b0;
      #1;
      check("mr_hs0", hs_send, 1'b0);
      check("mr_ack0", hs_is_ack, 1'b0);
      check("mr_ok0", txn_ok, 1'b0);
      check("mr_rx0", rx_data, 64'h0);
      check("mr_used0", attempts_used, 4'd0);
      hs_done = 1'b1;
      tick();
      hs_done = 1'b0;
      check("mr_nodone", txn_done, 1'b0);
      rst_L = 1'b1;
      tick();
      check("mr_nodone2", txn_done, 1'b0);
      start_txn(1'b0);
      launch("mr_go2");
      dec_haveack = 1'b1;
      tick();
      dec_haveack = 1'b0;
      done_chk("mr", 1'b1, 4'd1);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
